// File: rtl/sf_interp_if.sv
// Streaming handshake bundle for sf_interp.
//   in_data/in_valid/in_ready    : decimated sample stream into the block
//   out_data/out_valid/out_ready : full-rate interpolated stream out of the block
// slave  = the interpolator side, master = producer/consumer side.
interface sf_interp_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/sf_interp.sv
// Linear-interpolating upsampler: each decimated input expands to FILT_SIZE
// output samples ramping toward the next input; the last input of a frame is
// held flat for FILT_SIZE samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a frame when idle
//   bus        : in_* (decimated stream in), out_* (interpolated stream out)
//   busy       : frame in progress
//   done       : one-cycle pulse at frame end
module sf_interp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FILT_SIZE  = 4,
   parameter int unsigned IN_LEN     = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   sf_interp_if.slave  bus,
   output logic        busy,
   output logic        done
);

   localparam int unsigned KW = $clog2(FILT_SIZE);
   localparam int unsigned SW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
   localparam int unsigned PW = DATA_WIDTH + 1 + KW;
   localparam logic [KW-1:0] K_LAST  = KW'(FILT_SIZE - 1);
   localparam logic [SW-1:0] SEG_PEN = SW'((IN_LEN >= 2) ? IN_LEN - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_FIRST,
      S_WAIT_NEXT,
      S_EMIT,
      S_EMIT_LAST,
      S_DONE
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] cur;
   logic [DATA_WIDTH-1:0] nxt;
   logic [KW-1:0]         k;
   logic [SW-1:0]         seg;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = bus.in_valid  && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;

   // cur + floor((nxt - cur) * kk / FILT_SIZE); the result always lies between
   // a and b, so dropping the upper bits is exact.
   function automatic logic [DATA_WIDTH-1:0] interp(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [KW-1:0]         kk
   );
      logic signed [DATA_WIDTH:0] diff;
      logic signed [PW-1:0]       prod;
      diff = $signed({1'b0, b}) - $signed({1'b0, a});
      prod = PW'(diff) * $signed(PW'(kk));
      return DATA_WIDTH'($signed(PW'(a)) + (prod >>> KW));
   endfunction

   // Frame sequencer; every output, including out_data, is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cur          <= '0;
         nxt          <= '0;
         k            <= '0;
         seg          <= '0;
         bus.in_ready <= 1'b0;
         bus.out_valid<= 1'b0;
         bus.out_data <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state        <= S_LOAD_FIRST;
                  seg          <= '0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b1;
               end
            end

            S_LOAD_FIRST: begin
               if (in_xfer) begin
                  cur <= bus.in_data;
                  if (IN_LEN == 1) begin
                     // Single-sample frame: go straight to the flat tail.
                     state         <= S_EMIT_LAST;
                     k             <= '0;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= bus.in_data;
                  end else begin
                     state <= S_WAIT_NEXT;
                  end
               end
            end

            S_WAIT_NEXT: begin
               if (in_xfer) begin
                  nxt           <= bus.in_data;
                  k             <= '0;
                  state         <= S_EMIT;
                  bus.in_ready  <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= cur;
               end
            end

            S_EMIT: begin
               if (out_xfer) begin
                  if (k == K_LAST) begin
                     cur <= nxt;
                     seg <= seg + SW'(1);
                     k   <= '0;
                     if (seg == SEG_PEN) begin
                        state        <= S_EMIT_LAST;
                        bus.out_data <= nxt;
                     end else begin
                        state         <= S_WAIT_NEXT;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                     end
                  end else begin
                     k            <= k + KW'(1);
                     bus.out_data <= interp(cur, nxt, k + KW'(1));
                  end
               end
            end

            S_EMIT_LAST: begin
               if (out_xfer) begin
                  if (k == K_LAST) begin
                     k             <= '0;
                     state         <= S_DONE;
                     bus.out_valid <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state         <= S_IDLE;
               bus.in_ready  <= 1'b0;
               bus.out_valid <= 1'b0;
               busy          <= 1'b0;
               done          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sf_interp.sv
// Scoreboard bench for sf_interp: two instances (IN_LEN=3 and IN_LEN=1)
// selected by 'sel'; expected samples come from an integer floor model.
module tb_sf_interp;

   localparam int unsigned DW = 8;
   localparam int unsigned FS = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sel;
   logic          start_d;
   logic          in_valid_d;
   logic [DW-1:0] in_data_d;
   logic          out_ready_d;

   logic busy3, done3, busy1, done1;
   logic start3, start1;

   logic          o_valid, o_in_ready, o_busy, o_done;
   logic [DW-1:0] o_data;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   sf_interp_if #(.DATA_WIDTH(DW)) b3 ();
   sf_interp_if #(.DATA_WIDTH(DW)) b1 ();

   assign b3.in_valid  = !sel && in_valid_d;
   assign b3.in_data   = in_data_d;
   assign b3.out_ready = !sel && out_ready_d;
   assign b1.in_valid  = sel && in_valid_d;
   assign b1.in_data   = in_data_d;
   assign b1.out_ready = sel && out_ready_d;
   assign start3       = !sel && start_d;
   assign start1       = sel && start_d;

   assign o_valid    = sel ? b1.out_valid : b3.out_valid;
   assign o_data     = sel ? b1.out_data  : b3.out_data;
   assign o_in_ready = sel ? b1.in_ready  : b3.in_ready;
   assign o_busy     = sel ? busy1        : busy3;
   assign o_done     = sel ? done1        : done3;

   sf_interp #(.DATA_WIDTH(DW), .FILT_SIZE(FS), .IN_LEN(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start3),
      .bus   (b3),
      .busy  (busy3),
      .done  (done3)
   );

   sf_interp #(.DATA_WIDTH(DW), .FILT_SIZE(FS), .IN_LEN(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .bus   (b1),
      .busy  (busy1),
      .done  (done1)
   );

   // a + floor((b - a) * k / FS) using plain integer division
   function automatic int model(input int a, input int b, input int k);
      int v;
      v = (b - a) * k;
      if (v >= 0) return a + v / int'(FS);
      else        return a - ((-v + int'(FS) - 1) / int'(FS));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame: start pulse, feed n inputs, drain n*FS outputs.
   // gap: idle in_ready cycles before each input; bp: random out_ready;
   // poke: start pulses during EMIT and in the done cycle;
   // abort_at >= 0: assert rst_n while beat abort_at+1 is presented.
   task automatic run_frame(input int n, input int v0, input int v1, input int v2,
                            input int gap, input bit bp, input bit poke, input int abort_at);
      int vals[3];
      int idx = 0;
      int wait_cnt = 0;
      int n_out = 0;
      int e;
      bit last_pend = 1'b0;
      bit hold_chk = 1'b0;
      bit poked = 1'b0;
      logic [DW-1:0] held = '0;
      vals[0] = v0; vals[1] = v1; vals[2] = v2;
      exp_q.delete();
      @(negedge clk); start_d = 1'b1;
      @(negedge clk); start_d = 1'b0;
      chk("busy_after_start", 32'(o_busy), 32'd1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold_chk) begin
            chk("stall_data_hold", 32'(o_data), 32'(held));
            chk("stall_valid_hold", 32'(o_valid), 32'd1);
         end
         if (last_pend) begin
            chk("done_pulse", 32'(o_done), 32'd1);
            chk("busy_in_done", 32'(o_busy), 32'd1);
            start_d = poke;
            in_valid_d = 1'b0;
            out_ready_d = 1'b0;
            @(negedge clk);
            start_d = 1'b0;
            chk("done_fall", 32'(o_done), 32'd0);
            chk("busy_fall", 32'(o_busy), 32'd0);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            chk("idle_after_done", 32'(o_busy), 32'd0);
            chk("idle_in_ready", 32'(o_in_ready), 32'd0);
            return;
         end
         chk("no_early_done", 32'(o_done), 32'd0);
         if (o_valid)    chk("in_ready_low_emit", 32'(o_in_ready), 32'd0);
         if (o_in_ready) chk("out_valid_low_wait", 32'(o_valid), 32'd0);
         if (abort_at >= 0 && n_out == abort_at && o_valid) begin
            if (exp_q.size() > 0) chk("pre_reset_beat", 32'(o_data), 32'(exp_q[0]));
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", 32'(o_valid), 32'd0);
            chk("rst_out_data", 32'(o_data), 32'd0);
            chk("rst_in_ready", 32'(o_in_ready), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            exp_q.delete();
            in_valid_d = 1'b0;
            out_ready_d = 1'b0;
            start_d = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_idle", 32'(o_busy), 32'd0);
            return;
         end
         start_d = 1'b0;
         if (poke && !poked && o_valid) begin
            start_d = 1'b1;
            poked = 1'b1;
         end
         in_valid_d  = (idx < n) && (wait_cnt >= gap);
         in_data_d   = (idx < n) ? DW'(vals[idx]) : '0;
         out_ready_d = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (in_valid_d && o_in_ready) begin
            if (idx >= 1)
               for (int k = 0; k < int'(FS); k++) exp_q.push_back(model(vals[idx-1], vals[idx], k));
            if (idx == n - 1)
               repeat (FS) exp_q.push_back(vals[idx]);
            idx++;
            wait_cnt = 0;
         end else if (o_in_ready) begin
            wait_cnt++;
         end
         if (o_valid && out_ready_d) begin
            if (exp_q.size() == 0) chk("queue_underflow", 32'(exp_q.size()), 32'd1);
            else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(o_data), 32'(e));
            end
            n_out++;
            hold_chk = 1'b0;
            if (n_out == n * int'(FS)) last_pend = 1'b1;
         end else if (o_valid) begin
            hold_chk = 1'b1;
            held = o_data;
         end else begin
            hold_chk = 1'b0;
         end
         @(negedge clk);
      end
      tests++;
      fails++;
      $error("FAIL timeout: frame outputs %0d expected %0d", n_out, n * int'(FS));
      in_valid_d = 1'b0;
      out_ready_d = 1'b0;
      start_d = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      sel = 1'b0;
      start_d = 1'b0;
      in_valid_d = 1'b0;
      in_data_d = '0;
      out_ready_d = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 32'(o_valid), 32'd0);
      chk("reset_out_data", 32'(o_data), 32'd0);
      chk("reset_in_ready", 32'(o_in_ready), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_done", 32'(o_done), 32'd0);
      chk("reset_busy_len1", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_start", 32'(o_busy), 32'd0);

      // Ramp up, descending, extreme swing.
      run_frame(3, 0, 8, 16, 0, 1'b0, 1'b0, -1);
      run_frame(3, 10, 3, 3, 0, 1'b0, 1'b0, -1);
      run_frame(3, 255, 0, 0, 0, 1'b0, 1'b0, -1);
      // Backpressure, input gaps, both together.
      run_frame(3, 0, 8, 16, 0, 1'b1, 1'b0, -1);
      run_frame(3, 0, 8, 16, 5, 1'b0, 1'b0, -1);
      run_frame(3, 200, 37, 90, 5, 1'b1, 1'b0, -1);
      // Stray start pulses during EMIT and DONE.
      run_frame(3, 0, 8, 16, 0, 1'b0, 1'b1, -1);
      // Single-sample frame.
      @(negedge clk); sel = 1'b1;
      run_frame(1, 42, 0, 0, 0, 1'b0, 1'b0, -1);
      @(negedge clk); sel = 1'b0;
      // Reset mid-frame then a clean frame.
      run_frame(3, 0, 8, 16, 0, 1'b0, 1'b0, 5);
      run_frame(3, 0, 8, 16, 0, 1'b0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
